// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader: state encoding,
// default handshake bytes and the 32-bit word type.
package loader_pkg;

    typedef logic [31:0] r32;

    localparam logic [2:0] ST_LEN    = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_ACK_TX = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_ERR_TX = 3'd5;
    localparam logic [2:0] ST_HALT   = 3'd6;

    typedef enum logic [2:0] {
        LEN    = ST_LEN,
        CHECK  = ST_CHECK,
        DATA   = ST_DATA,
        ACK_TX = ST_ACK_TX,
        RUN    = ST_RUN,
        ERR_TX = ST_ERR_TX,
        HALT   = ST_HALT
    } loader_state_e;

    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word/word_valid are
// presented combinationally together with the 4th push of each group.
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic [7:0] byte_in,
    output r32         word,
    output logic       word_valid
);

    r32         shreg;
    logic [1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (push) begin
            shreg <= word;
            cnt   <= cnt + 2'd1;
        end
    end

    // Earlier bytes slide toward bit 0, so the first byte lands in [7:0].
    assign word       = {byte_in, shreg[31:8]};
    assign word_valid = push && (cnt == 2'd3);

endmodule

// File: rtl/uart_boot_loader.sv
// Boot sequencer: receives a length-prefixed program over UART, writes it to
// instruction memory, acknowledges the host and then releases the core.
module uart_boot_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned SIZE_W   = 16,
    parameter logic [7:0]  ACK_BYTE = DEFAULT_ACK_BYTE,
    parameter logic [7:0]  ERR_BYTE = DEFAULT_ERR_BYTE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SIZE_W-1:0] recv_size,
    input  logic [7:0]        recv_rd,
    output logic              recv_en,
    input  logic              send_busy,
    output logic              send_en,
    output logic [7:0]        send_content,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              load_done
);

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    loader_state_e   state;
    r32              count;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] index_next;
    r32              word;
    logic            word_valid;

    assign recv_en    = ((state == LEN) || (state == DATA)) && (recv_size != '0);
    assign send_en    = ((state == ACK_TX) || (state == ERR_TX)) && !send_busy;
    assign core_reset = (state != RUN);
    assign load_done  = (state == RUN);
    assign index_next = index + (ADDR_W + 1)'(1);

    byte_word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == CHECK),
        .push       (recv_en),
        .byte_in    (recv_rd),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= LEN;
            count        <= '0;
            index        <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            send_content <= '0;
        end else begin
            imem_we <= 1'b0;
            unique case (state)
                LEN: begin
                    if (word_valid) begin
                        count <= word;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    index <= '0;
                    // send_content is loaded here so it is stable before the pulse.
                    if ({1'b0, count} > CAPACITY) begin
                        send_content <= ERR_BYTE;
                        state        <= ERR_TX;
                    end else if (count == '0) begin
                        send_content <= ACK_BYTE;
                        state        <= ACK_TX;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= index[ADDR_W-1:0];
                        imem_wdata <= word;
                        index      <= index_next;
                        if (r32'(index_next) == count) begin
                            send_content <= ACK_BYTE;
                            state        <= ACK_TX;
                        end
                    end
                end
                ACK_TX: if (!send_busy) state <= RUN;
                ERR_TX: if (!send_busy) state <= HALT;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a FWFT FIFO model feeds host bytes,
// a monitor collects memory writes and sent bytes for comparison.
module tb_uart_boot_loader;
    import loader_pkg::*;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned SIZE_W = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [SIZE_W-1:0] recv_size = '0;
    logic [7:0]        recv_rd = '0;
    logic              recv_en;
    logic              send_busy = 1'b0;
    logic              send_en;
    logic [7:0]        send_content;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset;
    logic              load_done;

    always #5 clock = ~clock;

    uart_boot_loader #(
        .ADDR_W   (ADDR_W),
        .SIZE_W   (SIZE_W),
        .ACK_BYTE (8'hAA),
        .ERR_BYTE (8'hEE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .recv_size    (recv_size),
        .recv_rd      (recv_rd),
        .recv_en      (recv_en),
        .send_busy    (send_busy),
        .send_en      (send_en),
        .send_content (send_content),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done)
    );

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [7:0]          fifo[$];
    logic [ADDR_W+31:0]  exp_wr[$];
    logic [ADDR_W+31:0]  got_wr[$];
    logic [7:0]          got_tx[$];
    logic [ADDR_W+31:0]  e_wr;
    logic [ADDR_W+31:0]  g_wr;
    logic [7:0]          g_tx;
    int unsigned         bad_send = 0;
    int unsigned         recv_en_cnt = 0;
    bit                  flush = 1'b0;
    bit                  gap_mode = 1'b0;
    bit                  will_pop = 1'b0;
    int unsigned         gap_cnt = 0;

    // FIFO model: pops decided just after inputs settle, applied next negedge.
    always @(negedge clock) begin
        if (flush) begin
            fifo.delete();
            flush   = 1'b0;
            gap_cnt = 0;
        end else if (will_pop) begin
            fifo.delete(0);
            if (gap_mode) gap_cnt = $urandom_range(20, 1);
        end else if (gap_cnt != 0) begin
            gap_cnt--;
        end
        recv_size = (gap_cnt == 0) ? SIZE_W'(fifo.size()) : '0;
        recv_rd   = (fifo.size() != 0) ? fifo[0] : 8'h00;
        #1 will_pop = recv_en && (recv_size != '0);
    end

    always @(negedge clock) begin
        #3;
        if (imem_we) got_wr.push_back({imem_addr, imem_wdata});
        if (send_en) begin
            got_tx.push_back(send_content);
            if (send_busy) bad_send++;
        end
        if (recv_en) recv_en_cnt++;
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) fifo.push_back(w[8*i +: 8]);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        flush    = 1'b1;
        gap_mode = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        got_wr.delete();
        got_tx.delete();
        exp_wr.delete();
        recv_en_cnt = 0;
    endtask

    task automatic send_two_word_program();
        push_word(32'd2);
        push_word(32'h44332211); exp_wr.push_back({14'd0, 32'h44332211});
        push_word(32'h88776655); exp_wr.push_back({14'd1, 32'h88776655});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #3;
        total++; if (recv_en !== 1'b0) $display("FAIL reset_recv_en got %b want 0", recv_en); else passed++;
        total++; if (send_en !== 1'b0) $display("FAIL reset_send_en got %b want 0", send_en); else passed++;
        total++; if (send_content !== 8'h00) $display("FAIL reset_send_content got %h want 00", send_content); else passed++;
        total++; if ({imem_we, imem_addr, imem_wdata} !== '0) $display("FAIL reset_imem got %b/%h/%h want 0", imem_we, imem_addr, imem_wdata); else passed++;
        total++; if ({core_reset, load_done} !== 2'b10) $display("FAIL reset_core got %b%b want 10", core_reset, load_done); else passed++;
        do_reset();
    endtask

    task automatic test_basic_load();
        do_reset();
        send_two_word_program();
        for (int i = 0; i < 400 && !load_done; i++) @(negedge clock);
        @(negedge clock);
        total++; if (load_done !== 1'b1 || core_reset !== 1'b0) $display("FAIL basic_release got done=%b core_reset=%b want 1/0", load_done, core_reset); else passed++;
        while (exp_wr.size() != 0) begin
            e_wr = exp_wr.pop_front();
            g_wr = (got_wr.size() != 0) ? got_wr.pop_front() : 'x;
            total++; if (g_wr !== e_wr) $display("FAIL basic_write got %h want %h", g_wr, e_wr); else passed++;
        end
        total++; if (got_wr.size() != 0) $display("FAIL basic_extra_writes got %0d want 0", got_wr.size()); else passed++;
        g_tx = (got_tx.size() != 0) ? got_tx.pop_front() : 'x;
        total++; if (g_tx !== 8'hAA || got_tx.size() != 0) $display("FAIL basic_ack got %h (+%0d more) want aa", g_tx, got_tx.size()); else passed++;
        fifo.push_back(8'h5A); fifo.push_back(8'hA5);
        recv_en_cnt = 0;
        repeat (10) @(negedge clock);
        total++; if (fifo.size() != 2 || recv_en_cnt != 0) $display("FAIL run_no_pop got fifo=%0d recv_en_cycles=%0d want 2/0", fifo.size(), recv_en_cnt); else passed++;
    endtask

    task automatic test_zero_count();
        do_reset();
        push_word(32'd0);
        for (int i = 0; i < 100 && !load_done; i++) @(negedge clock);
        @(negedge clock);
        total++; if (load_done !== 1'b1 || core_reset !== 1'b0) $display("FAIL zero_release got done=%b core_reset=%b want 1/0", load_done, core_reset); else passed++;
        total++; if (got_wr.size() != 0) $display("FAIL zero_writes got %0d want 0", got_wr.size()); else passed++;
        g_tx = (got_tx.size() != 0) ? got_tx.pop_front() : 'x;
        total++; if (g_tx !== 8'hAA || got_tx.size() != 0) $display("FAIL zero_ack got %h want aa", g_tx); else passed++;
    endtask

    task automatic test_oversize();
        do_reset();
        push_word((32'd1 << ADDR_W) + 32'd1);
        for (int i = 0; i < 100 && got_tx.size() == 0; i++) @(negedge clock);
        g_tx = (got_tx.size() != 0) ? got_tx.pop_front() : 'x;
        total++; if (g_tx !== 8'hEE) $display("FAIL err_byte got %h want ee", g_tx); else passed++;
        push_word(32'hCAFEF00D);
        repeat (2) @(negedge clock);
        recv_en_cnt = 0;
        repeat (30) @(negedge clock);
        total++; if (recv_en_cnt != 0 || fifo.size() != 4) $display("FAIL halt_no_pop got recv_en_cycles=%0d fifo=%0d want 0/4", recv_en_cnt, fifo.size()); else passed++;
        total++; if (core_reset !== 1'b1 || load_done !== 1'b0) $display("FAIL halt_core got core_reset=%b done=%b want 1/0", core_reset, load_done); else passed++;
        total++; if (got_wr.size() != 0 || got_tx.size() != 0) $display("FAIL halt_quiet got writes=%0d sends=%0d want 0/0", got_wr.size(), got_tx.size()); else passed++;
    endtask

    task automatic test_capacity_boundary();
        do_reset();
        push_word(32'd1 << ADDR_W);
        push_word(32'hDEADBEEF); exp_wr.push_back({14'd0, 32'hDEADBEEF});
        repeat (40) @(negedge clock);
        e_wr = exp_wr.pop_front();
        g_wr = (got_wr.size() != 0) ? got_wr.pop_front() : 'x;
        total++; if (g_wr !== e_wr) $display("FAIL cap_first_write got %h want %h", g_wr, e_wr); else passed++;
        total++; if (got_tx.size() != 0 || core_reset !== 1'b1) $display("FAIL cap_still_loading got sends=%0d core_reset=%b want 0/1", got_tx.size(), core_reset); else passed++;
    endtask

    task automatic test_send_busy();
        do_reset();
        send_busy = 1'b1;
        push_word(32'd0);
        repeat (50) @(negedge clock);
        total++; if (got_tx.size() != 0 || core_reset !== 1'b1) $display("FAIL busy_wait got sends=%0d core_reset=%b want 0/1", got_tx.size(), core_reset); else passed++;
        send_busy = 1'b0;
        for (int i = 0; i < 20 && !load_done; i++) @(negedge clock);
        repeat (5) @(negedge clock);
        g_tx = (got_tx.size() != 0) ? got_tx.pop_front() : 'x;
        total++; if (g_tx !== 8'hAA || got_tx.size() != 0 || load_done !== 1'b1) $display("FAIL busy_release got %h (+%0d) done=%b want aa/0/1", g_tx, got_tx.size(), load_done); else passed++;
    endtask

    task automatic test_gaps();
        do_reset();
        gap_mode = 1'b1;
        send_two_word_program();
        for (int i = 0; i < 2000 && !load_done; i++) @(negedge clock);
        @(negedge clock);
        total++; if (load_done !== 1'b1) $display("FAIL gap_release got done=%b want 1", load_done); else passed++;
        while (exp_wr.size() != 0) begin
            e_wr = exp_wr.pop_front();
            g_wr = (got_wr.size() != 0) ? got_wr.pop_front() : 'x;
            total++; if (g_wr !== e_wr) $display("FAIL gap_write got %h want %h", g_wr, e_wr); else passed++;
        end
        g_tx = (got_tx.size() != 0) ? got_tx.pop_front() : 'x;
        total++; if (got_wr.size() != 0 || g_tx !== 8'hAA) $display("FAIL gap_tail got extra_writes=%0d ack=%h want 0/aa", got_wr.size(), g_tx); else passed++;
        gap_mode = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        push_word(32'd2);
        push_word(32'h44332211);
        fifo.push_back(8'h55); fifo.push_back(8'h66);
        for (int i = 0; i < 100 && fifo.size() != 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        g_wr = (got_wr.size() != 0) ? got_wr.pop_front() : 'x;
        total++; if (g_wr !== {14'd0, 32'h44332211} || got_wr.size() != 0) $display("FAIL mid_partial got %h (+%0d) want 000044332211", g_wr, got_wr.size()); else passed++;
        do_reset();
        send_two_word_program();
        for (int i = 0; i < 400 && !load_done; i++) @(negedge clock);
        @(negedge clock);
        while (exp_wr.size() != 0) begin
            e_wr = exp_wr.pop_front();
            g_wr = (got_wr.size() != 0) ? got_wr.pop_front() : 'x;
            total++; if (g_wr !== e_wr) $display("FAIL mid_write got %h want %h", g_wr, e_wr); else passed++;
        end
        total++; if (got_wr.size() != 0 || load_done !== 1'b1) $display("FAIL mid_tail got extra_writes=%0d done=%b want 0/1", got_wr.size(), load_done); else passed++;
        total++; if (bad_send != 0) $display("FAIL send_while_busy got %0d want 0", bad_send); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_count();
        test_oversize();
        test_capacity_boundary();
        test_send_busy();
        test_gaps();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
